// File: rtl/core_rst_seq_if.sv
// ---------------------------------------------------------------------------
// axi4_if : AXI4 bundle used on the core_rst_seq register port.
//
// Signal groups (32-bit address and data, ID_W-bit IDs):
//   AW : awid, awaddr, awlen, awvalid, awready
//   W  : wdata, wstrb, wlast, wvalid, wready
//   B  : bid, bresp, bvalid, bready
//   AR : arid, araddr, arlen, arvalid, arready
//   R  : rid, rdata, rresp, rlast, rvalid, rready
// Modports: master (drives requests), slave (drives responses).
//
// Handshake rule for every channel: a beat transfers on the rising clk edge
// where both VALID and READY are high. Once a source raises VALID it holds
// VALID and its payload stable until that edge. READY may rise or fall at
// any time and never waits on VALID from the same side.
// ---------------------------------------------------------------------------
interface axi4_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/core_rst_seq.sv
// ---------------------------------------------------------------------------
// core_rst_seq : per-core reset sequencer with an AXI4 register port.
//
// Software asserts core resets (REQ_RST) and queues releases (REQ_REL).
// Each core keeps its reset for at least HOLD_CYCLES+1 clocks. Releases are
// granted round-robin, one at a time, each followed by a GAP_CYCLES idle gap.
//
// Ports:
//   clk_i       clock
//   rst_n       synchronous active-low reset
//   s           AXI4 slave register port (0x0 N_CORES, 0x4 REQ_RST,
//               0x8 REQ_REL, 0xC STATUS)
//   core_rst_n  per-core active-low reset, bit i drives core i
//   busy        a release is pending or a gap is running
//   dbg_state_o scheduler state (0 idle, 1 gap)
// ---------------------------------------------------------------------------
module core_rst_seq #(
    parameter int AXI_ID_WIDTH = 4,
    parameter int N_CORES      = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 8,
    parameter logic [N_CORES-1:0] BOOT_MASK = N_CORES'(1)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    axi4_if.slave              s,
    output logic [N_CORES-1:0] core_rst_n,
    output logic               busy,
    output logic [0:0]         dbg_state_o
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = $clog2(N_CORES);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_V  = GW'(GAP_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GAP  = 1'b1;

    localparam logic [1:0] A_NCORES  = 2'd0;
    localparam logic [1:0] A_REQ_RST = 2'd1;
    localparam logic [1:0] A_REQ_REL = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    // scheduler state
    logic [0:0]         state_q, state_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [N_CORES-1:0] core_q, core_d, pend_q, pend_d, elig;
    logic [HW-1:0]      hold_q [N_CORES];
    logic [HW-1:0]      hold_d [N_CORES];
    logic               grant_any;
    logic [IW-1:0]      grant_idx;

    // AXI channel state
    logic                    ar_busy_q, rvalid_q;
    logic [1:0]              rsel_q;
    logic [AXI_ID_WIDTH-1:0] rid_q;
    logic [7:0]              rcnt_q;
    logic                    aw_busy_q, wready_q, bvalid_q;
    logic [1:0]              wsel_q;
    logic [AXI_ID_WIDTH-1:0] bid_q;

    logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic          idx_ok, cmd_rst, cmd_rel;
    logic [IW-1:0] cmd_idx;
    logic [31:0]   rd_val;

    assign ar_hs = s.arvalid & ~ar_busy_q;
    assign r_hs  = rvalid_q & s.rready;
    assign aw_hs = s.awvalid & ~aw_busy_q;
    assign w_hs  = s.wvalid & wready_q;
    assign b_hs  = bvalid_q & s.bready;

    // Out-of-range indices are silently dropped; the write still completes.
    assign idx_ok  = (s.wdata < 32'(N_CORES));
    assign cmd_idx = s.wdata[IW-1:0];
    assign cmd_rst = w_hs & idx_ok & (wsel_q == A_REQ_RST);
    assign cmd_rel = w_hs & idx_ok & (wsel_q == A_REQ_REL);

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            elig[i] = pend_q[i] & (hold_q[i] == '0);
        end
    end

    // First eligible core at or above the rr pointer, wrapping at N_CORES.
    always_comb begin : grant_search
        logic [IW:0] sum;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 0; k < N_CORES; k++) begin
            sum = {1'b0, rr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_CORES)) begin
                sum = sum - (IW+1)'(N_CORES);
            end
            if (!grant_any && elig[sum[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[IW-1:0];
            end
        end
    end

    // Priority on a single core: REQ_RST over grant over REQ_REL.
    always_comb begin
        core_d  = core_q;
        pend_d  = pend_q;
        state_d = state_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        for (int i = 0; i < N_CORES; i++) begin
            hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - 1'b1 : '0;
        end
        if (cmd_rel && !core_q[cmd_idx]) begin
            pend_d[cmd_idx] = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    core_d[grant_idx] = 1'b1;
                    pend_d[grant_idx] = 1'b0;
                    rr_d    = (grant_idx == IW'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
                    gap_d   = GAP_V;
                    state_d = S_GAP;
                end
            end
            default: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
        endcase
        if (cmd_rst) begin
            core_d[cmd_idx] = 1'b0;
            hold_d[cmd_idx] = HOLD_V;
            pend_d[cmd_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            rr_q    <= '0;
            core_q  <= '0;
            pend_q  <= BOOT_MASK;
            for (int i = 0; i < N_CORES; i++) begin
                hold_q[i] <= HOLD_V;
            end
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            core_q  <= core_d;
            pend_q  <= pend_d;
            for (int i = 0; i < N_CORES; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    // Read path: one register, ARLEN+1 beats, AR blocked until the last beat.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            ar_busy_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rsel_q    <= '0;
            rid_q     <= '0;
            rcnt_q    <= '0;
        end else if (ar_hs) begin
            ar_busy_q <= 1'b1;
            rvalid_q  <= 1'b1;
            rsel_q    <= s.araddr[3:2];
            rid_q     <= s.arid;
            rcnt_q    <= s.arlen;
        end else if (r_hs) begin
            if (rcnt_q == '0) begin
                rvalid_q  <= 1'b0;
                ar_busy_q <= 1'b0;
            end else begin
                rcnt_q <= rcnt_q - 1'b1;
            end
        end
    end

    // Write path: each W beat is a command; B follows the WLAST beat.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            aw_busy_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            wsel_q    <= '0;
            bid_q     <= '0;
        end else begin
            if (aw_hs) begin
                aw_busy_q <= 1'b1;
                wready_q  <= 1'b1;
                wsel_q    <= s.awaddr[3:2];
                bid_q     <= s.awid;
            end
            if (w_hs && s.wlast) begin
                wready_q <= 1'b0;
                bvalid_q <= 1'b1;
            end
            if (b_hs) begin
                bvalid_q  <= 1'b0;
                aw_busy_q <= 1'b0;
            end
        end
    end

    assign busy = (pend_q != '0) | (state_q == S_GAP);

    always_comb begin
        rd_val = '0;
        case (rsel_q)
            A_NCORES: rd_val = 32'(N_CORES);
            A_STATUS: begin
                rd_val[N_CORES-1:0]   = core_q;
                rd_val[16 +: N_CORES] = pend_q;
                rd_val[31]            = busy;
            end
            default: rd_val = '0;
        endcase
    end

    assign s.arready = ~ar_busy_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rvalid_q ? rd_val : '0;
    assign s.rid     = rvalid_q ? rid_q : '0;
    assign s.rlast   = rvalid_q & (rcnt_q == '0);
    assign s.rresp   = 2'b00;
    assign s.awready = ~aw_busy_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = 2'b00;

    assign core_rst_n  = core_q;
    assign dbg_state_o = state_q;

    logic unused_ok;
    assign unused_ok = ^{s.awaddr[31:4], s.awaddr[1:0], s.araddr[31:4],
                         s.araddr[1:0], s.awlen, s.wstrb};
endmodule

// File: tb/tb_core_rst_seq.sv
module tb_core_rst_seq;
    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam logic [N-1:0] BOOT = 4'b0001;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_if #(.ID_W(4)) bus ();
    logic [N-1:0] core_rst_n;
    logic         busy;
    logic [0:0]   dbg_state;

    core_rst_seq #(
        .AXI_ID_WIDTH(4), .N_CORES(N), .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .BOOT_MASK(BOOT)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .s(bus),
        .core_rst_n(core_rst_n), .busy(busy), .dbg_state_o(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard queues: R beats {last, id, sel}, B responses {id}
    logic [6:0] rd_q[$];
    logic [3:0] b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: timestamps (edge numbers) instead of counters.
    // Edge 0 is the last reset edge; a core asserted at edge a may be released
    // at edge e when e-1-a >= HOLD; a release at edge r blocks grants until r+GAP+2.
    bit           m_on = 1'b0;
    int           m_cyc;
    logic [N-1:0] m_rst_n, m_pend;
    int           m_assert [N];
    int           m_last_rel;
    int           m_rr;
    logic [1:0]   m_wsel;

    function automatic logic m_gap();
        return (m_cyc - m_last_rel) <= GAP;
    endfunction

    function automatic logic m_busy();
        return (m_pend != '0) || m_gap();
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] v = '0;
        v[N-1:0]   = m_rst_n;
        v[16 +: N] = m_pend;
        v[31]      = m_busy();
        return v;
    endfunction

    task automatic m_reset();
        m_cyc = 0; m_rst_n = '0; m_pend = BOOT; m_last_rel = -1000; m_rr = 0; m_wsel = 2'd0;
        for (int i = 0; i < N; i++) m_assert[i] = 0;
    endtask

    task automatic m_step();
        int g = -1;
        int idx;
        bit w_beat, do_rst, do_rel;
        logic [N-1:0] np;
        if (m_cyc - m_last_rel > GAP) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (g < 0 && m_pend[c] && (m_cyc - m_assert[c] >= HOLD)) g = c;
            end
        end
        w_beat = bus.wvalid && bus.wready && (bus.wdata < N);
        idx    = w_beat ? int'(bus.wdata) : 0;
        do_rst = w_beat && (m_wsel == 2'd1);
        do_rel = w_beat && (m_wsel == 2'd2);
        np = m_pend;
        if (do_rel && !m_rst_n[idx]) np[idx] = 1'b1;
        if (g >= 0) begin
            m_rst_n[g] = 1'b1; np[g] = 1'b0; m_rr = (g + 1) % N; m_last_rel = m_cyc + 1;
        end
        if (do_rst) begin
            m_rst_n[idx] = 1'b0; m_assert[idx] = m_cyc + 1; np[idx] = 1'b0;
        end
        m_pend = np;
        m_cyc++;
        if (bus.awvalid && bus.awready) m_wsel = bus.awaddr[3:2];
    endtask

    // Monitor: compares state, pops scoreboard on R/B beats, then advances model.
    always @(negedge clk) begin
        logic [6:0]  re;
        logic [31:0] ed;
        if (m_on) begin
            check("core_rst_n", 32'(core_rst_n), 32'(m_rst_n));
            check("busy", 32'(busy), 32'(m_busy()));
            check("dbg_state", 32'(dbg_state), 32'(m_gap()));
        end
        if (rst_n && bus.rvalid && bus.rready) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL r_unexpected: got beat rdata 0x%0h expected none", bus.rdata);
            end else begin
                re = rd_q.pop_front();
                ed = (re[1:0] == 2'd0) ? 32'(N) : (re[1:0] == 2'd3) ? m_status() : 32'd0;
                check("rdata", bus.rdata, ed);
                check("rid", 32'(bus.rid), 32'(re[5:2]));
                check("rlast", 32'(bus.rlast), 32'(re[6]));
                check("rresp", 32'(bus.rresp), 32'd0);
            end
        end
        if (rst_n && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected: got bid 0x%0h expected none", bus.bid);
            end else begin
                check("bid", 32'(bus.bid), 32'(b_q.pop_front()));
                check("bresp", 32'(bus.bresp), 32'd0);
            end
        end
        if (!rst_n) begin
            m_reset();
            m_on = 1'b1;
        end else if (m_on) begin
            m_step();
        end
    end

    // driver tasks: entered and left at posedge+1
    task automatic wait_hs(input int ch, input string name);
        int t = 0;
        bit ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            case (ch)
                0: ok = bus.awready;
                1: ok = bus.wready;
                2: ok = bus.bvalid && bus.bready;
                default: ok = bus.arready;
            endcase
            t++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL timeout_%s: got no handshake expected one within 300 clocks", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input int beats, input logic [3:0] id);
        b_q.push_back(id);
        bus.awid = id; bus.awaddr = {28'd0, addr}; bus.awlen = 8'(beats - 1);
        bus.awvalid = 1'b1;
        wait_hs(0, "aw");
        bus.awvalid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            bus.wdata = data; bus.wstrb = 4'($urandom); bus.wlast = (b == beats - 1);
            bus.wvalid = 1'b1;
            wait_hs(1, "w");
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        wait_hs(2, "b");
    endtask

    task automatic axi_read(input logic [3:0] addr, input int len,
                            input logic [3:0] id, input bit toggle);
        int cnt = 0;
        int t = 0;
        for (int b = 0; b <= len; b++) rd_q.push_back({(b == len), id, addr[3:2]});
        bus.arid = id; bus.araddr = {28'd0, addr}; bus.arlen = 8'(len); bus.arvalid = 1'b1;
        wait_hs(3, "ar");
        bus.arvalid = 1'b0;
        bus.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cnt <= len && t < 300) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) cnt++;
            t++;
            @(posedge clk); #1;
            bus.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (cnt <= len) begin
            n_checks++;
            $display("FAIL timeout_r: got %0d beats expected %0d", cnt, len + 1);
        end
        bus.rready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_not_busy(input string name);
        int t = 0;
        while (busy && t < 500) begin idle(1); t++; end
        if (busy) begin
            n_checks++;
            $display("FAIL timeout_%s: got busy=1 expected 0 within 500 clocks", name);
        end
    endtask

    task automatic boot_timing(input string tag);
        int cnt = 0;
        while (!core_rst_n[0] && cnt < 100) begin idle(1); cnt++; end
        check({tag, "_release_clks"}, 32'(cnt), 32'd17);
        check({tag, "_others_low"}, 32'(core_rst_n[3:1]), 32'd0);
        cnt = 0;
        while (busy && cnt < 100) begin idle(1); cnt++; end
        check({tag, "_busy_drop_clks"}, 32'(cnt), 32'd9);
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        rst_n = 1'b1;

        // boot release timing
        boot_timing("boot");

        // round-robin release of 3, 1, 2
        axi_write(4'h8, 32'd3, 1, 4'd1);
        axi_write(4'h8, 32'd1, 1, 4'd2);
        axi_write(4'h8, 32'd2, 1, 4'd3);
        wait_not_busy("rr");
        check("rr_all_out", 32'(core_rst_n), 32'hF);
        axi_read(4'hC, 0, 4'd1, 1'b0);

        // reset and re-release core 2 with STATUS read while waiting
        axi_write(4'h4, 32'd2, 1, 4'd4);
        axi_write(4'h8, 32'd2, 1, 4'd5);
        axi_read(4'hC, 1, 4'd2, 1'b0);
        wait_not_busy("rerel");
        check("rerel_all_out", 32'(core_rst_n), 32'hF);

        // assert during pending: core 3 never released
        axi_write(4'h4, 32'd2, 1, 4'd6);
        axi_write(4'h4, 32'd3, 1, 4'd7);
        idle(20);
        axi_write(4'h8, 32'd2, 1, 4'd8);
        axi_write(4'h8, 32'd3, 1, 4'd9);
        axi_write(4'h4, 32'd3, 1, 4'd10);
        wait_not_busy("cancel");
        idle(30);
        check("cancel_cores", 32'(core_rst_n), 32'h7);
        axi_read(4'hC, 0, 4'd3, 1'b0);

        // read bursts of N_CORES
        axi_read(4'h0, 3, 4'd5, 1'b0);
        axi_read(4'h0, 3, 4'd5, 1'b1);

        // out-of-range index, 2-beat burst
        axi_write(4'h8, 32'd7, 2, 4'd11);
        idle(3);
        check("oor_no_change", 32'(core_rst_n), 32'h7);

        // reset pulse during a gap restarts boot
        axi_write(4'h8, 32'd3, 1, 4'd12);
        idle(2);
        check("gap_before_pulse", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("pulse_core_rst_n", 32'(core_rst_n), 32'd0);
        check("pulse_busy", 32'(busy), 32'd1);
        boot_timing("reboot");

        // randomized traffic on both paths
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [3:0] a;
                    case ($urandom_range(0, 3))
                        0: a = 4'h4;
                        1: a = 4'h0;
                        default: a = 4'h8;
                    endcase
                    axi_write(a, 32'($urandom_range(0, 5)), $urandom_range(1, 2),
                              4'($urandom_range(0, 15)));
                    idle($urandom_range(0, 12));
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    axi_read(4'($urandom_range(0, 3) * 4), $urandom_range(0, 3),
                             4'($urandom_range(0, 15)), 1'b1);
                    idle($urandom_range(0, 10));
                end
            end
        join
        wait_not_busy("final");
        idle(40);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("b_q_empty", 32'(b_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
